johnson_phase_monitor: RTL and testbench
========================================

Name: johnson_phase_monitor

Overview:
Downstream consumer of the 4-bit JK twisted-ring (Johnson) counter. Samples the counter's q bus every clock and decodes it to a phase index and a one-hot phase. Checks every step against the legal Johnson successor, runs a lock/fault state machine, and counts full revolutions and errors. Feeds the phase-sequenced control logic and the status register.

Parameters:
W, 4, Johnson counter width; legal code count = 2*W
LOCK_CNT, 4, consecutive correct transitions required to assert locked (1..15)
REV_W, 8, revolution counter width
ERR_W, 8, error counter width (saturating)

Ports:
clk  input  1  clock; all state on rising edge
clr  input  1  asynchronous active-low reset
en  input  1  sample enable; when 0, every register holds
state_in  input  W  counter state (q bus of the Johnson counter)
clear_err  input  1  single-cycle pulse: leave FAULT, zero err_cnt
phase_idx  output  $clog2(2*W)  decoded phase, registered
phase_onehot  output  2*W  one-hot of phase_idx; all zero when phase_valid=0
phase_valid  output  1  registered: last sampled state_in was a legal code
locked  output  1  FSM in LOCKED
fault  output  1  FSM in FAULT
rev_cnt  output  REV_W  completed revolutions while locked; wraps
err_cnt  output  ERR_W  illegal-transition count; saturates at all-ones

Behaviour:
- Reset (clr=0, asynchronous): all outputs 0; FSM=UNLOCKED; prev_state=0; prev_valid=0; good_cnt=0.
- Legal codes, in index order for W=4: 0000,1000,1100,1110,1111,0111,0011,0001 (idx 0..7). General successor: next(s) = {~s[0], s[W-1:1]}.
- Latency: phase_idx, phase_onehot and phase_valid reflect the state_in sampled on the previous enabled edge (1 cycle).
- legal = state_in is in the code set.
- ok = prev_valid && state_in == next(prev_state).
- stall = prev_valid && state_in == prev_state.
- Every enabled edge: prev_state <= state_in; prev_valid <= legal.
- FSM (evaluated only when en=1):
  - UNLOCKED: if legal, go to ACQUIRE with good_cnt=0.
  - ACQUIRE: ok increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED. Otherwise, if legal, stay and set good_cnt=0; if not legal, go to UNLOCKED.
  - LOCKED: ok stays. Any other input goes to FAULT, increments err_cnt (saturating) and clears locked.
  - FAULT: sticky. clear_err goes to UNLOCKED and zeroes err_cnt.
- clear_err outside FAULT only zeroes err_cnt. If a new fault and clear_err arrive in the same cycle, the fault wins: FAULT is entered, err_cnt increments, and clear_err is ignored.
- rev_cnt increments in LOCKED when ok and state_in is code idx 0 (entry from idx 2W-1). It wraps at 2^REV_W and holds outside LOCKED.
- Illegal state_in (e.g. 0101) gives phase_valid=0 and phase_onehot=0 next cycle; phase_idx holds its last legal value.
- en is also honoured during FAULT; clear_err acts regardless of en.

Optional Feature:
- Macro: JMON_STALL_TOL_EN.
- Defined: stall is neutral. It neither increments good_cnt nor faults, rev_cnt does not increment, and the FSM holds. This tolerates a gated counter clock.
- Undefined: stall is treated as a bad transition (ACQUIRE resets good_cnt; LOCKED goes to FAULT).

Decomposition:
- Package jmon_pkg holds:
  - FSM state typedef: UNLOCKED, ACQUIRE, LOCKED, FAULT.
  - Function johnson_next(s).
  - Function johnson_idx(s), which returns index plus legal bit.
  - Localparam for phase-index width.
- One sub-module, johnson_decode: purely combinational state_in to {legal, idx}, instantiated once.

Test Plan:
- Bench config W=4, LOCK_CNT=4.
- Basic lock: reset, then feed 0,8,12,14,15 on consecutive edges -> phase_idx 0,1,2,3,4 one cycle later; locked=1 in the cycle after the 15 is sampled.
- Revolutions: locked, continue the sequence through 3 full cycles ending at 0 -> rev_cnt=3, err_cnt=0, fault=0.
- Illegal code: locked, inject 0101 -> next cycle fault=1, locked=0, err_cnt=1, phase_valid=0. Pulse clear_err -> UNLOCKED, err_cnt=0. Resume 0,8,... -> relock after 4 good transitions.
- Skip: locked, 8 followed by 14 -> fault=1, err_cnt=1. Fault and clear_err in the same cycle -> fault=1, err_cnt increments.
- Reset mid-operation: drive clr low asynchronously while LOCKED with rev_cnt=5 -> all outputs 0 before the next clk edge; FSM UNLOCKED after release.
- Stall: locked, 12 followed by 12 -> no fault with JMON_STALL_TOL_EN; fault=1 and err_cnt=1 without it.

Source files
------------

// File: rtl/jmon_pkg.sv
// -----------------------------------------------------------------------------
// jmon_pkg
// Shared types and helpers for the Johnson-counter phase monitor.
//   jmon_state_t   : lock/fault FSM state
//   johnson_next() : legal successor of a W-bit Johnson code
//   johnson_idx()  : {legal, index} lookup of a W-bit Johnson code
// The helpers work on JMON_MAX_W-bit vectors plus an explicit width so one
// definition serves every W up to JMON_MAX_W; callers zero-extend their input.
// Optional build macro used by the monitor: JMON_STALL_TOL_EN.
// -----------------------------------------------------------------------------
package jmon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } jmon_state_t;

    localparam int JMON_MAX_W     = 16;
    localparam int JMON_DEF_W     = 4;
    // Phase-index width for the default counter and for the widest supported one.
    localparam int JMON_IDX_W     = $clog2(2 * JMON_DEF_W);
    localparam int JMON_IDX_W_MAX = $clog2(2 * JMON_MAX_W);

    // next(s) = {~s[0], s[w-1:1]}; bits at and above w stay zero.
    function automatic logic [JMON_MAX_W-1:0] johnson_next(
        input logic [JMON_MAX_W-1:0] s,
        input int                    w
    );
        logic [JMON_MAX_W-1:0] r;
        logic [JMON_MAX_W-1:0] sh;
        r  = '0;
        sh = s >> 1;
        for (int i = 0; i < JMON_MAX_W; i++) begin
            if (i == w - 1) begin
                r[i] = ~s[0];
            end else if (i < w - 1) begin
                r[i] = sh[i];
            end
        end
        return r;
    endfunction

    // Walks the 2*w legal codes from all-zeros; MSB of the result is the legal bit.
    function automatic logic [JMON_IDX_W_MAX:0] johnson_idx(
        input logic [JMON_MAX_W-1:0] s,
        input int                    w
    );
        logic [JMON_MAX_W-1:0]   c;
        logic [JMON_IDX_W_MAX:0] res;
        c   = '0;
        res = '0;
        for (int k = 0; k < 2 * JMON_MAX_W; k++) begin
            if ((k < 2 * w) && !res[JMON_IDX_W_MAX] && (c == s)) begin
                res = {1'b1, JMON_IDX_W_MAX'(k)};
            end
            c = johnson_next(c, w);
        end
        return res;
    endfunction

endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// -----------------------------------------------------------------------------
// johnson_decode
// Purely combinational decode of a Johnson counter state into its phase index.
//   state_in [W-1:0]          : counter q bus
//   legal                     : state_in is one of the 2*W legal codes
//   idx [$clog2(2*W)-1:0]     : phase index (0 when not legal)
// -----------------------------------------------------------------------------
module johnson_decode
    import jmon_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]             state_in,
    output logic                     legal,
    output logic [$clog2(2*W)-1:0]   idx
);

    logic [JMON_IDX_W_MAX:0] lookup;
    logic                    unused_lookup;

    assign lookup        = johnson_idx(JMON_MAX_W'(state_in), W);
    assign legal         = lookup[JMON_IDX_W_MAX];
    assign idx           = lookup[$clog2(2*W)-1:0];
    // Upper index bits are always zero for this W.
    assign unused_lookup = ^lookup;

endmodule

// File: rtl/johnson_phase_monitor.sv
// -----------------------------------------------------------------------------
// johnson_phase_monitor
// Samples a W-bit Johnson counter every enabled clock, decodes it to a phase,
// checks each step against the legal successor, runs an
// UNLOCKED/ACQUIRE/LOCKED/FAULT state machine, and counts revolutions/errors.
//
// Ports:
//   clk           : clock, all state on rising edge
//   clr           : asynchronous active-low reset
//   en            : sample enable; 0 holds every register (clear_err excepted)
//   state_in      : counter q bus
//   clear_err     : pulse; leaves FAULT and zeroes err_cnt
//   phase_idx     : decoded phase of the last legal sample (holds on illegal)
//   phase_onehot  : one-hot of phase_idx, zero when phase_valid=0
//   phase_valid   : last sample was a legal code
//   locked, fault : FSM in LOCKED / FAULT
//   rev_cnt       : revolutions completed while locked (wraps)
//   err_cnt       : illegal transitions seen while locked (saturates)
//
// Build option: define JMON_STALL_TOL_EN to make a repeated code (stall)
// neutral, so a gated counter clock does not break lock.
// -----------------------------------------------------------------------------
module johnson_phase_monitor
    import jmon_pkg::*;
#(
    parameter int W        = 4,
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic [W-1:0]            state_in,
    input  logic                    clear_err,
    output logic [$clog2(2*W)-1:0]  phase_idx,
    output logic [2*W-1:0]          phase_onehot,
    output logic                    phase_valid,
    output logic                    locked,
    output logic                    fault,
    output logic [REV_W-1:0]        rev_cnt,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int IW = $clog2(2 * W);
    localparam int GW = $clog2(LOCK_CNT + 1);

    logic              dec_legal;
    logic [IW-1:0]     dec_idx;

    logic [W-1:0]      prev_state_reg;
    logic              prev_valid_reg;
    logic [IW-1:0]     phase_idx_reg;

    jmon_state_t       state_reg, state_next;
    logic [GW-1:0]     good_reg, good_next;
    logic [REV_W-1:0]  rev_reg, rev_next;
    logic [ERR_W-1:0]  err_reg, err_next;

    logic [W-1:0]      next_exp;
    logic              ok;
    logic              stall;
    logic              neutral;
    logic              fault_evt;

    johnson_decode #(.W(W)) u_decode (
        .state_in (state_in),
        .legal    (dec_legal),
        .idx      (dec_idx)
    );

    assign next_exp = W'(johnson_next(JMON_MAX_W'(prev_state_reg), W));
    assign ok       = prev_valid_reg && (state_in == next_exp);
    assign stall    = prev_valid_reg && (state_in == prev_state_reg);

`ifdef JMON_STALL_TOL_EN
    assign neutral = stall;
`else
    // A repeated code is just another bad transition in this build.
    assign neutral = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        rev_next   = rev_reg;
        err_next   = err_reg;
        fault_evt  = 1'b0;

        if (en) begin
            case (state_reg)
                UNLOCKED: begin
                    if (dec_legal) begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end
                end
                ACQUIRE: begin
                    if (!neutral) begin
                        if (ok) begin
                            if (int'(good_reg) + 1 >= LOCK_CNT) begin
                                state_next = LOCKED;
                                good_next  = '0;
                            end else begin
                                good_next = good_reg + GW'(1);
                            end
                        end else if (dec_legal) begin
                            good_next = '0;
                        end else begin
                            state_next = UNLOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        // Wrapping into code 0 closes one revolution.
                        if (dec_idx == '0) begin
                            rev_next = rev_reg + REV_W'(1);
                        end
                    end else if (!neutral) begin
                        fault_evt  = 1'b1;
                        state_next = FAULT;
                        if (err_reg != '1) begin
                            err_next = err_reg + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    // FAULT is sticky until clear_err.
                end
            endcase
        end

        // clear_err ignores en, but a fault arriving in the same cycle wins.
        if (clear_err && !fault_evt) begin
            err_next = '0;
            if (state_reg == FAULT) begin
                state_next = UNLOCKED;
                good_next  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev_state_reg <= '0;
            prev_valid_reg <= 1'b0;
            phase_idx_reg  <= '0;
            state_reg      <= UNLOCKED;
            good_reg       <= '0;
            rev_reg        <= '0;
            err_reg        <= '0;
        end else begin
            state_reg <= state_next;
            good_reg  <= good_next;
            rev_reg   <= rev_next;
            err_reg   <= err_next;
            if (en) begin
                prev_state_reg <= state_in;
                prev_valid_reg <= dec_legal;
                if (dec_legal) begin
                    phase_idx_reg <= dec_idx;
                end
            end
        end
    end

    // prev_valid_reg is exactly "last sample was legal", so it doubles as phase_valid.
    genvar gi;
    generate
        for (gi = 0; gi < 2 * W; gi++) begin : g_onehot
            assign phase_onehot[gi] = prev_valid_reg && (phase_idx_reg == IW'(gi));
        end
    endgenerate

    assign phase_idx   = phase_idx_reg;
    assign phase_valid = prev_valid_reg;
    assign locked      = (state_reg == LOCKED);
    assign fault       = (state_reg == FAULT);
    assign rev_cnt     = rev_reg;
    assign err_cnt     = err_reg;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// -----------------------------------------------------------------------------
// tb_johnson_phase_monitor
// Scoreboard bench for johnson_phase_monitor (W=4, LOCK_CNT=4). The driver
// applies one transaction per cycle on the falling edge and pushes the
// expected post-edge outputs from an index-based reference model; the monitor
// pops and compares one entry after each rising edge.
// -----------------------------------------------------------------------------
module tb_johnson_phase_monitor;

    localparam int W        = 4;
    localparam int LOCK_CNT = 4;
    localparam int NCODES   = 2 * W;

`ifdef JMON_STALL_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif

    localparam int S_UNL = 0;
    localparam int S_ACQ = 1;
    localparam int S_LCK = 2;
    localparam int S_FLT = 3;

    logic        clk;
    logic        clr;
    logic        en;
    logic [3:0]  state_in;
    logic        clear_err;
    logic [2:0]  phase_idx;
    logic [7:0]  phase_onehot;
    logic        phase_valid;
    logic        locked;
    logic        fault;
    logic [7:0]  rev_cnt;
    logic [7:0]  err_cnt;

    johnson_phase_monitor #(
        .W        (W),
        .LOCK_CNT (LOCK_CNT),
        .REV_W    (8),
        .ERR_W    (8)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .en           (en),
        .state_in     (state_in),
        .clear_err    (clear_err),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .phase_valid  (phase_valid),
        .locked       (locked),
        .fault        (fault),
        .rev_cnt      (rev_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s_in;
        int e_in;
        int c_in;
        int pidx;
        int pv;
        int oh;
        int lk;
        int ft;
        int rev;
        int err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (phase tracked as an index, not as a bit pattern)
    int m_state, m_good, m_rev, m_err, m_prev_ci, m_pidx;

    // k-th legal code: k ones entering from the top, then draining from the top.
    function automatic int code_of(input int k);
        if (k <= W) return ((1 << k) - 1) << (W - k);
        return (1 << (NCODES - k)) - 1;
    endfunction

    function automatic int code_index(input int v);
        for (int k = 0; k < NCODES; k++) begin
            if (code_of(k) == v) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = S_UNL;
        m_good    = 0;
        m_rev     = 0;
        m_err     = 0;
        m_prev_ci = -1;
        m_pidx    = 0;
    endtask

    task automatic model_step(input bit e, input int s, input bit ce);
        int   ci;
        bit   ok, stall, neutral, fevt;
        exp_t x;
        ci   = code_index(s);
        fevt = 1'b0;
        if (e) begin
            ok      = (m_prev_ci >= 0) && (ci == (m_prev_ci + 1) % NCODES);
            stall   = (m_prev_ci >= 0) && (ci == m_prev_ci);
            neutral = TOL && stall;
            case (m_state)
                S_UNL: if (ci >= 0) begin m_state = S_ACQ; m_good = 0; end
                S_ACQ: begin
                    if (!neutral) begin
                        if (ok) begin
                            m_good++;
                            if (m_good == LOCK_CNT) begin m_state = S_LCK; m_good = 0; end
                        end else if (ci >= 0) begin
                            m_good = 0;
                        end else begin
                            m_state = S_UNL;
                        end
                    end
                end
                S_LCK: begin
                    if (ok) begin
                        if (ci == 0) m_rev = (m_rev + 1) % 256;
                    end else if (!neutral) begin
                        fevt    = 1'b1;
                        m_state = S_FLT;
                        m_err   = (m_err < 255) ? m_err + 1 : 255;
                    end
                end
                default: ;
            endcase
            m_prev_ci = ci;
            if (ci >= 0) m_pidx = ci;
        end
        if (ce && !fevt) begin
            m_err = 0;
            if (m_state == S_FLT) m_state = S_UNL;
        end
        x.s_in = s;
        x.e_in = e;
        x.c_in = ce;
        x.pidx = m_pidx;
        x.pv   = (m_prev_ci >= 0);
        x.oh   = (m_prev_ci >= 0) ? (1 << m_pidx) : 0;
        x.lk   = (m_state == S_LCK);
        x.ft   = (m_state == S_FLT);
        x.rev  = m_rev;
        x.err  = m_err;
        q.push_back(x);
    endtask

    // Monitor: one transaction completes on each rising edge that has a queued entry.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                $display("txn in=%h en=%0d clr_err=%0d idx=%0d pv=%0d oh=%b lk=%0d ft=%0d rev=%0d err=%0d",
                         x.s_in, x.e_in, x.c_in, phase_idx, phase_valid, phase_onehot,
                         locked, fault, rev_cnt, err_cnt);
                chk("phase_idx",    int'(phase_idx),    x.pidx);
                chk("phase_valid",  int'(phase_valid),  x.pv);
                chk("phase_onehot", int'(phase_onehot), x.oh);
                chk("locked",       int'(locked),       x.lk);
                chk("fault",        int'(fault),        x.ft);
                chk("rev_cnt",      int'(rev_cnt),      x.rev);
                chk("err_cnt",      int'(err_cnt),      x.err);
            end
        end
    end

    task automatic step(input bit e, input int s, input bit ce);
        @(negedge clk);
        en        = e;
        state_in  = 4'(s);
        clear_err = ce;
        model_step(e, s, ce);
    endtask

    task automatic feed(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, code_of((start + k) % NCODES), 1'b0);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        en        = 1'b0;
        clear_err = 1'b0;
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        chk("rst_phase_idx",    int'(phase_idx),    0);
        chk("rst_phase_valid",  int'(phase_valid),  0);
        chk("rst_phase_onehot", int'(phase_onehot), 0);
        chk("rst_locked",       int'(locked),       0);
        chk("rst_fault",        int'(fault),        0);
        chk("rst_rev_cnt",      int'(rev_cnt),      0);
        chk("rst_err_cnt",      int'(err_cnt),      0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, s, cur;
        clr       = 1'b0;
        en        = 1'b0;
        state_in  = 4'h0;
        clear_err = 1'b0;
        model_reset();

        // Basic lock and three revolutions ending on code 0
        do_reset();
        feed(0, 5);
        feed(5, 20);

        // Illegal code while locked, clear with en low, then relock
        step(1'b1, 4'b0101, 1'b0);
        step(1'b0, 0, 1'b1);
        feed(0, 5);

        // Skip 8 -> 14 while locked
        feed(5, 4);
        feed(1, 1);
        step(1'b1, code_of(3), 1'b0);
        step(1'b1, code_of(0), 1'b1);
        feed(1, 5);
        // Fault and clear_err together: fault wins
        step(1'b1, 4'b0101, 1'b1);
        step(1'b1, code_of(0), 1'b1);

        // Stall 12 -> 12 while locked
        feed(1, 5);
        feed(6, 5);
        step(1'b1, code_of(2), 1'b0);
        feed(3, 3);

        // Reset mid-operation with rev_cnt = 5
        do_reset();
        feed(0, 5);
        feed(5, 36);
        do_reset();

        // rev_cnt wrap after 256 revolutions
        feed(0, 5);
        feed(5, 8 * 256);
        do_reset();

        // Randomized traffic
        cur = 0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(99, 0);
            if (r < 75)      s = code_of((cur + 1) % NCODES);
            else if (r < 85) s = code_of(cur);
            else if (r < 93) s = code_of($urandom_range(NCODES - 1, 0));
            else begin
                do s = $urandom_range(15, 0); while (code_index(s) >= 0);
            end
            if (code_index(s) >= 0) cur = code_index(s);
            step($urandom_range(99, 0) < 90, s, $urandom_range(99, 0) < 5);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
